md_unit_mc: RTL and testbench
=============================

Name: md_unit_mc

Overview:
- Multi-cycle multiply/divide unit with the HI/LO register pair, sitting in the EX stage of the pipelined core.
- Consumes the forwarded rs/rt operands and the decoded MD op from the EX-stage datapath.
- Produces the committed HI/LO read data for mfhi/mflo.
- Produces a stall request consumed by the upstream hazard unit, which freezes D/F while a multiply or divide is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- A  input  32  operand rs (forwarded)
- B  input  32  operand rt (forwarded)
- op  input  3  000 none, 001 multu, 010 mult, 011 divu, 100 div, 101 mtlo, 110 mthi, 111 none
- start  input  1  op valid this cycle (EX-stage instruction is an MD op)
- rd_sel  input  1  0 select LO, 1 select HI for rd_data
- rd_data  output  32  committed HI or LO (combinational from registers)
- busy  output  1  multi-cycle operation in flight
- stall_req  output  1  start&(op is MD-class or mfhi/mflo-dependent) | busy; see below
- div_zero  output  1  one-cycle pulse: a divide with B==0 completed

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On a reset edge:
  - HI=0, LO=0, state=IDLE, counter=0.
  - busy=0 and div_zero=0.
  - Any in-flight operation is discarded; HI/LO are not updated.
- States: IDLE, MUL, DIV.
- Accepting a multiply or divide (IDLE, start=1, op in {001..100}):
  - A and B are latched into internal operand registers at that edge.
  - Counter loads MULT_CYCLES-1 or DIV_CYCLES-1 and the FSM enters MUL or DIV.
- busy timing:
  - busy is 1 from the cycle after acceptance for exactly MULT_CYCLES / DIV_CYCLES cycles.
  - The counter decrements each cycle while busy.
- Commit: at the edge ending the last busy cycle (counter==0), HI/LO are written and the FSM returns to IDLE.
  - busy is 0 in the following cycle.
  - Back-to-back: a new start in that same IDLE cycle is accepted.
- Results:
  - multu: {HI,LO} = zero-extended A × zero-extended B, full 64-bit product.
  - mult: {HI,LO} = sign-extended 64-bit product.
  - divu: LO = A/B, HI = A%B (unsigned).
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div edge case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B==0 at acceptance):
  - Full busy duration still elapses.
  - HI/LO stay unchanged.
  - div_zero pulses for 1 cycle in the cycle after the commit edge.
- mtlo / mthi:
  - In IDLE with start=1: LO or HI is written from A at the next edge.
  - No busy, single cycle.
- start while busy: ignored by the unit (no latch, no write).
  - The hazard unit must have stalled it; the bench asserts this never occurs.
- stall_req = busy | (start & op in {001..110} & state!=IDLE).
  - The hazard unit additionally ORs in mfhi/mflo-in-D while busy.
  - Net effect: every MD-class or HI/LO-reading instruction waits until busy=0.
- rd_data:
  - rd_data = rd_sel ? HI : LO, combinational from the committed registers.
  - During busy it shows the old values.
  - A same-cycle mtlo/mthi is not bypassed; the value is visible in the next cycle.
- Operand latching: the result depends only on operands latched at acceptance; A/B changes during busy have no effect.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES))+1 bits.

Decomposition:
- Shared package md_pkg holds:
  - op encodings: MD_NONE, MD_MULTU, MD_MULT, MD_DIVU, MD_DIV, MD_MTLO, MD_MTHI.
  - FSM state typedef (IDLE, MUL, DIV).
  - Default latency constants.
- One sub-module, md_compute: purely combinational.
  - Inputs: latched operands and latched op.
  - Outputs: 64-bit {hi,lo} result and a div_by_zero flag.
- The FSM, counter and HI/LO registers stay in md_unit_mc.

Test Plan:
- Reset mid-operation: mult 3×4, then reset on busy cycle 2 -> HI=LO=0, busy=0 next cycle, no later commit.
- Signed multiply: mult A=0xFFFFFFFE(-2), B=3 -> busy exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed divide: div A=0xFFFFFFF9(-7), B=2 -> busy exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: HI=0x11, LO=0x22, then divu B=0 -> after 10 busy cycles HI/LO unchanged, div_zero high for exactly 1 cycle.
- Moves, operand latching, reads: mthi A=0xDEADBEEF then mtlo A=0x12345678 -> rd_sel=1 reads 0xDEADBEEF, rd_sel=0 reads 0x12345678, busy never set.
  - Then multu 0xFFFFFFFF×0xFFFFFFFF, A/B toggled during busy -> HI=0xFFFFFFFE, LO=0x00000001.
  - rd_data shows the old values until commit.
- Back-to-back and ignored start: start divu on the first cycle busy=0 after a mult commit -> accepted, busy re-asserts next cycle.
  - A start pulsed mid-busy -> no effect on HI/LO or timing; stall_req=1 throughout busy.

Source files
------------

// File: rtl/md_unit_mc_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM states and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULTU = 3'd1,
    MD_MULT  = 3'd2,
    MD_DIVU  = 3'd3,
    MD_DIV   = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_NONE7 = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that touch HI/LO and therefore must wait for the unit to go idle.
  function automatic logic is_md_class(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

endpackage

// File: rtl/md_unit_mc_compute.sv
// Combinational result generator for latched multiply/divide operands.
// Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
module md_compute
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        signed_op;
  logic        is_div;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_out;
  logic [31:0] r_out;

  always_comb begin
    signed_op   = (op == MD_MULT) || (op == MD_DIV);
    is_div      = (op == MD_DIVU) || (op == MD_DIV);
    a_ext       = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext       = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
    a_mag       = (signed_op && a[31]) ? (32'd0 - a) : a;
    b_mag       = (signed_op && b[31]) ? (32'd0 - b) : b;
    div_by_zero = is_div && (b == 32'd0);
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end else begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end
    // Quotient sign follows operand signs; remainder follows the dividend.
    q_out = (signed_op && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    r_out = (signed_op && a[31]) ? (32'd0 - r_mag) : r_mag;
    case (op)
      MD_MULTU, MD_MULT: result = a_ext * b_ext;
      MD_DIVU, MD_DIV:   result = {r_out, q_out};
      default:           result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit_mc.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results commit after a fixed latency; the stall request holds the front end.
module md_unit_mc
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  op,
  input  logic        start,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall_req,
  output logic        div_zero
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  md_state_e   state;
  logic [CW-1:0] cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [63:0] result;
  logic        dz;

  md_compute u_compute (
    .a           (a_q),
    .b           (b_q),
    .op          (op_q),
    .result      (result),
    .div_by_zero (dz)
  );

  // FSM, latency counter, operand latches and the HI/LO pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 3'd0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MD_MULTU, MD_MULT: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op;
                cnt   <= CW'(MULT_CYCLES - 1);
                state <= ST_MUL;
                busy  <= 1'b1;
              end
              MD_DIVU, MD_DIV: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op;
                cnt   <= CW'(DIV_CYCLES - 1);
                state <= ST_DIV;
                busy  <= 1'b1;
              end
              MD_MTLO: lo <= A;
              MD_MTHI: hi <= A;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            // A divide by zero leaves HI/LO intact and only raises the flag.
            if (dz) begin
              div_zero <= 1'b1;
            end else begin
              hi <= result[63:32];
              lo <= result[31:0];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data   = rd_sel ? hi : lo;
  assign stall_req = busy | (start & is_md_class(op) & (state != ST_IDLE));

endmodule

// File: tb/tb_md_unit_mc.sv
// Self-checking bench for md_unit_mc: directed scenarios plus random ops
// checked against a plain-arithmetic HI/LO model.
module tb_md_unit_mc;

  localparam logic [2:0] OP_MULTU = 3'd1, OP_MULT = 3'd2, OP_DIVU = 3'd3,
                         OP_DIV = 3'd4, OP_MTLO = 3'd5, OP_MTHI = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic [2:0]  op = 3'd0;
  logic        start = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        busy, stall_req, div_zero;

  int n_err = 0;
  int n_chk = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic        exp_dz = 1'b0;

  md_unit_mc #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .stall_req(stall_req),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic int exp_busy(input logic [2:0] o);
    if (o == OP_MULTU || o == OP_MULT) return 5;
    if (o == OP_DIVU || o == OP_DIV) return 10;
    return 0;
  endfunction

  // Reference model: what HI/LO must hold after the op completes.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a); ub = longint'(b);
    exp_dz = 1'b0;
    case (o)
      OP_MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_DIVU: if (ub == 0) exp_dz = 1'b1;
               else begin q = ua / ub; r = ua % ub; m_lo = q[31:0]; m_hi = r[31:0]; end
      OP_DIV:  if (sb == 0) exp_dz = 1'b1;
               else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      OP_MTLO: m_lo = a;
      OP_MTHI: m_hi = a;
      default: ;
    endcase
  endtask

  // Issue one op (called at a negedge), follow it to idle; returns busy length
  // and a count of stall/old-value anomalies seen during busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit toggle, input bit pulse, output int nbusy, output int side_err);
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi; old_lo = m_lo;
    A = a; B = b; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    nbusy = 0; side_err = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) break;
      nbusy++;
      if (!stall_req) side_err++;
      rd_sel = k[0]; #1;
      if (rd_data !== (k[0] ? old_hi : old_lo)) side_err++;
      if (toggle) begin A = $urandom; B = $urandom; end
      if (pulse && nbusy == 2) begin start = 1'b1; op = OP_MTHI; A = 32'hBAD0BAD0; end
      else start = 1'b0;
    end
    start = 1'b0;
    model_op(o, a, b);
  endtask

  task automatic test_reset();
    int nb, se;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    rd_sel = 1'b1; #1;
    n_chk++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", rd_data); end
    rd_sel = 1'b0; #1;
    n_chk++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", rd_data); end
    reset = 1'b0;
    @(negedge clk);
    run_op(OP_MTHI, 32'h55, 32'd0, 1'b0, 1'b0, nb, se);
    run_op(OP_MTLO, 32'h66, 32'd0, 1'b0, 1'b0, nb, se);
    A = 32'd3; B = 32'd4; op = OP_MULT; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; op = 3'd0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rd_sel = 1'b1; #1;
    n_chk++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL midrst_hi: got %h want 0", rd_data); end
    repeat (8) @(negedge clk);
    rd_sel = 1'b0; #1;
    n_chk++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL midrst_nocommit: got %h want 0", rd_data); end
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit toggle, input bit pulse);
    int nb, se;
    run_op(o, a, b, toggle, pulse, nb, se);
    n_chk++; if (nb !== exp_busy(o)) begin n_err++; $display("FAIL %s_busy_len: got %0d want %0d", name, nb, exp_busy(o)); end
    n_chk++; if (se !== 0) begin n_err++; $display("FAIL %s_during_busy: got %0d anomalies want 0", name, se); end
    n_chk++; if (div_zero !== exp_dz) begin n_err++; $display("FAIL %s_dz: got %b want %b", name, div_zero, exp_dz); end
    rd_sel = 1'b1; #1;
    n_chk++; if (rd_data !== m_hi) begin n_err++; $display("FAIL %s_hi: got %h want %h", name, rd_data, m_hi); end
    rd_sel = 1'b0; #1;
    n_chk++; if (rd_data !== m_lo) begin n_err++; $display("FAIL %s_lo: got %h want %h", name, rd_data, m_lo); end
  endtask

  task automatic test_mult();
    check_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    n_chk++; if ({m_hi, m_lo} !== 64'hFFFFFFFF_FFFFFFFA) begin n_err++; $display("FAIL mult_model: got %h%h want FFFFFFFFFFFFFFFA", m_hi, m_lo); end
    check_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    n_chk++; if ({m_hi, m_lo} !== 64'h00000002_FFFFFFFA) begin n_err++; $display("FAIL multu_model: got %h%h want 00000002FFFFFFFA", m_hi, m_lo); end
  endtask

  task automatic test_div();
    check_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    n_chk++; if ({m_hi, m_lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL div_model: got %h%h want FFFFFFFFFFFFFFFD", m_hi, m_lo); end
    check_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    n_chk++; if ({m_hi, m_lo} !== 64'h00000000_80000000) begin n_err++; $display("FAIL div_ovf_model: got %h%h want 0000000080000000", m_hi, m_lo); end
  endtask

  task automatic test_div_zero();
    check_op("mthi11", OP_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
    check_op("mtlo22", OP_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
    check_op("divu0", OP_DIVU, 32'h1234, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL divu0_pulse_len: got %b want 0", div_zero); end
  endtask

  task automatic test_moves();
    check_op("mthi", OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    // Same-cycle move must not be bypassed onto rd_data.
    A = 32'h12345678; op = OP_MTLO; start = 1'b1; rd_sel = 1'b0; #1;
    n_chk++; if (rd_data !== m_lo) begin n_err++; $display("FAIL mtlo_nobypass: got %h want %h", rd_data, m_lo); end
    start = 1'b0; op = 3'd0;
    check_op("mtlo", OP_MTLO, 32'h12345678, 32'd0, 1'b0, 1'b0);
    check_op("multu_latch", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    n_chk++; if ({m_hi, m_lo} !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL multu_latch_model: got %h%h want FFFFFFFE00000001", m_hi, m_lo); end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_mult", OP_MULT, 32'd7, 32'hFFFFFFF0, 1'b0, 1'b0);
    check_op("b2b_divu", OP_DIVU, 32'd1000, 32'd7, 1'b0, 1'b0);
    check_op("pulse_div", OP_DIV, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(1, 6));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (i[0] ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'($urandom_range(0, 1000))};
      check_op("rand", o, a, b, i[1], i[2]);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_moves();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
